instruction_fetch_sequencer: RTL and testbench

Upstream stage of the instruction register. It holds the program counter and runs a memory read handshake for each fetch. When memory reports the word valid on the data bus, it pulses the IR's active-low load strobe for exactly one clock. It also provides PC load for jumps and a watchdog that flags a memory that never answers.

---
 rtl/instruction_fetch_sequencer.sv | 105 ++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter, runs one memory read
// handshake per fetch, strobes the IR load (active low) on the ready cycle and
// raises a sticky fault when memory fails to answer within WAIT_LIMIT cycles.
module instruction_fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  fetchReq,
  input  logic                  pcLoad,
  input  logic [ADDR_WIDTH-1:0] pcIn,
  input  logic                  memReady,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRead,
  output logic                  irNotLoad,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  busy,
  output logic                  fetched,
  output logic                  fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT} state_t;

  // Last REQ cycle before timeout; wait counter fits WAIT_LIMIT up to 255.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic                  r_memRead;
  logic                  r_fetched;
  logic                  r_fault;
  logic [7:0]            r_waitCnt;

  logic                  w_load;
  logic                  w_timeout;

  // IR load fires in the same cycle memory reports ready; reset masks it so
  // a ready arriving alongside reset never loads the IR.
  always_comb begin
    w_load    = notReset && (r_state == S_REQ) && memReady;
    w_timeout = (r_state == S_REQ) && !memReady && (r_waitCnt == LIMIT_M1);
  end

  // Fetch FSM with registered handshake outputs; ready wins over timeout.
  always_ff @(posedge clock) begin
    if (!notReset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_memAddr <= RESET_PC;
      r_memRead <= 1'b0;
      r_fetched <= 1'b0;
      r_fault   <= 1'b0;
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fetched <= 1'b0;
          if (pcLoad) r_pc <= pcIn;
          if (fetchReq) begin
            // A jump in the same cycle as the fetch request fetches the target.
            r_state   <= S_REQ;
            r_memRead <= 1'b1;
            r_waitCnt <= '0;
            r_memAddr <= pcLoad ? pcIn : r_pc;
          end
        end
        S_REQ: begin
          if (memReady) begin
            r_pc      <= r_pc + 1'b1;
            r_memRead <= 1'b0;
            r_fetched <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
            if (w_timeout) begin
              r_state   <= S_FAULT;
              r_fault   <= 1'b1;
              r_memRead <= 1'b0;
            end
          end
        end
        S_FAULT: begin
          r_fetched <= 1'b0;
          r_memRead <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    memAddr   = r_memAddr;
    memRead   = r_memRead;
    irNotLoad = ~w_load;
    pcOut     = r_pc;
    busy      = (r_state == S_REQ);
    fetched   = r_fetched;
    fault     = r_fault;
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: directed vector table, hand-written
// corner sequences and random traffic checked against a fetch-level model.
module tb_instruction_fetch_sequencer;

  localparam int AW  = 16;
  localparam int LIM = 15;

  logic          clock = 1'b0;
  logic          notReset, fetchReq, pcLoad, memReady;
  logic [AW-1:0] pcIn;
  logic [AW-1:0] memAddr, pcOut;
  logic          memRead, irNotLoad, busy, fetched, fault;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(16'h0000), .WAIT_LIMIT(LIM)) dut (
    .clock(clock), .notReset(notReset), .fetchReq(fetchReq), .pcLoad(pcLoad),
    .pcIn(pcIn), .memReady(memReady), .memAddr(memAddr), .memRead(memRead),
    .irNotLoad(irNotLoad), .pcOut(pcOut), .busy(busy), .fetched(fetched), .fault(fault)
  );

  always #5 clock = ~clock;

  // Model: a fetch is either outstanding or not; the memory has waited some cycles.
  bit            m_pending, m_fault, m_fetched;
  logic [AW-1:0] m_pc, m_addr;
  int            m_waited;

  typedef struct {
    bit            fr, pl, mr, rn;
    logic [AW-1:0] pin;
    logic [36:0]   exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [36:0] ex(logic [15:0] a, bit rd, bit nl, logic [15:0] pc,
                                     bit b, bit f, bit flt);
    return {a, rd, nl, pc, b, f, flt};
  endfunction

  function automatic logic [36:0] act();
    return {memAddr, memRead, irNotLoad, pcOut, busy, fetched, fault};
  endfunction

  task automatic cmp(input string nm, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got addr=%h rd=%b nl=%b pc=%h busy=%b fet=%b flt=%b | want addr=%h rd=%b nl=%b pc=%h busy=%b fet=%b flt=%b",
               nm, $time, got[36:21], got[20], got[19], got[18:3], got[2], got[1], got[0],
               exp[36:21], exp[20], exp[19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk1(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [36:0] model_out(bit mr, bit rn);
    return {m_addr, m_pending, !(rn && m_pending && mr), m_pc, m_pending, m_fetched, m_fault};
  endfunction

  task automatic model_step(bit fr, bit pl, logic [AW-1:0] pin, bit mr, bit rn);
    if (!rn) begin
      m_pending = 0; m_fault = 0; m_fetched = 0; m_pc = '0; m_addr = '0; m_waited = 0;
    end else if (m_fault) begin
      m_fetched = 0;
    end else if (m_pending) begin
      if (mr) begin
        m_pc = AW'((int'(m_pc) + 1) % 65536);
        m_pending = 0; m_fetched = 1;
      end else begin
        m_fetched = 0;
        m_waited++;
        if (m_waited == LIM) begin m_pending = 0; m_fault = 1; end
      end
    end else begin
      m_fetched = 0;
      if (fr) begin m_addr = pl ? pin : m_pc; m_pending = 1; m_waited = 0; end
      if (pl) m_pc = pin;
    end
  endtask

  // One clock: drive, compare against model (and optional fixed vector), advance.
  task automatic cyc(input bit fr, input bit pl, input logic [AW-1:0] pin, input bit mr,
                     input bit rn, input string nm, input bit has_exp = 0,
                     input logic [36:0] exp = '0);
    fetchReq = fr; pcLoad = pl; pcIn = pin; memReady = mr; notReset = rn;
    #2;
    cmp({nm, "/model"}, act(), model_out(mr, rn));
    if (has_exp) cmp({nm, "/vec"}, act(), exp);
    @(posedge clock);
    model_step(fr, pl, pin, mr, rn);
    #1;
  endtask

  task automatic do_reset();
    fetchReq = 0; pcLoad = 0; pcIn = '0; memReady = 0; notReset = 0;
    repeat (2) @(posedge clock);
    model_step(0, 0, '0, 0, 0);
    #1;
  endtask

  initial begin
    int rd_cnt;
    logic [AW-1:0] old_pc;

    tbl[0] = '{0, 0, 0, 1, 16'h0000, ex(16'h0000, 0, 1, 16'h0000, 0, 0, 0)};
    tbl[1] = '{1, 0, 0, 1, 16'h0000, ex(16'h0000, 0, 1, 16'h0000, 0, 0, 0)};
    tbl[2] = '{0, 0, 1, 1, 16'h0000, ex(16'h0000, 1, 0, 16'h0000, 1, 0, 0)};
    tbl[3] = '{0, 0, 0, 1, 16'h0000, ex(16'h0000, 0, 1, 16'h0001, 0, 1, 0)};
    tbl[4] = '{1, 1, 0, 1, 16'h1234, ex(16'h0000, 0, 1, 16'h0001, 0, 0, 0)};
    tbl[5] = '{0, 0, 0, 1, 16'h0000, ex(16'h1234, 1, 1, 16'h1234, 1, 0, 0)};
    tbl[6] = '{0, 0, 1, 1, 16'h0000, ex(16'h1234, 1, 0, 16'h1234, 1, 0, 0)};
    tbl[7] = '{0, 0, 0, 1, 16'h0000, ex(16'h1234, 0, 1, 16'h1235, 0, 1, 0)};
    tbl[8] = '{0, 0, 1, 1, 16'h0000, ex(16'h1234, 0, 1, 16'h1235, 0, 0, 0)};
    tbl[9] = '{0, 0, 0, 1, 16'h0000, ex(16'h1234, 0, 1, 16'h1235, 0, 0, 0)};

    do_reset();
    foreach (tbl[i])
      cyc(tbl[i].fr, tbl[i].pl, tbl[i].pin, tbl[i].mr, tbl[i].rn, $sformatf("vec%0d", i), 1, tbl[i].exp);

    // PC wrap at the top of the address space.
    cyc(1, 1, 16'hFFFF, 0, 1, "wrap_req");
    cyc(0, 0, 16'h0000, 1, 1, "wrap_rdy");
    chk1("wrap_pc", pcOut, 16'h0000);
    chk1("wrap_nofault", {15'd0, fault}, 16'h0000);

    // Slow memory with a jump attempt mid-request: the jump is dropped.
    old_pc = pcOut;
    cyc(1, 0, 16'h0000, 0, 1, "slow_req");
    cyc(0, 0, 16'h0000, 0, 1, "slow_w1");
    cyc(0, 1, 16'h4444, 0, 1, "slow_w2");
    cyc(0, 0, 16'h0000, 0, 1, "slow_w3");
    cyc(0, 0, 16'h0000, 1, 1, "slow_rdy");
    chk1("slow_pc", pcOut, old_pc + 16'd1);

    // Timeout: memRead holds for WAIT_LIMIT cycles then a sticky fault.
    cyc(1, 0, 16'h0000, 0, 1, "to_req");
    rd_cnt = 0;
    for (int k = 0; k < LIM + 3; k++) begin
      if (memRead) rd_cnt++;
      cyc(0, 0, 16'h0000, 0, 1, "to_wait");
    end
    chk1("to_rd_cycles", 16'(rd_cnt), 16'(LIM));
    chk1("to_fault", {14'd0, fault, memRead}, 16'h0002);
    for (int k = 0; k < 4; k++) cyc(1, 1, 16'h7777, 1, 1, "to_ignored");
    cyc(0, 0, 16'h0000, 0, 0, "to_rst");
    chk1("to_rst_pc", pcOut, 16'h0000);
    chk1("to_rst_fault", {15'd0, fault}, 16'h0000);

    // Reset while memory answers: no IR load, no fetched pulse.
    cyc(1, 1, 16'h0042, 0, 1, "rr_req");
    cyc(0, 0, 16'h0000, 1, 0, "rr_rst_rdy");
    chk1("rr_state", {pcOut[7:0], 4'd0, memRead, busy, fetched, fault}, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, "rr_after");

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bit fr, pl, mr, rn;
      logic [AW-1:0] pin;
      fr  = ($urandom_range(0, 1) == 1);
      pl  = ($urandom_range(0, 3) == 0);
      mr  = ($urandom_range(0, 9) < 3);
      rn  = ($urandom_range(0, 49) != 0);
      pin = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      cyc(fr, pl, pin, mr, rn, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
